// File: rtl/data_plane_tx_mc.sv
// Multi-channel transmit data plane: per-channel FIFOs drained by a round-robin
// arbiter into one registered {node_id, data} packet with a valid/ready output.
module data_plane_tx_mc #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        gpp_tx_signal,
  input  logic [NUM_CH*DATA_W-1:0] gpp_tx_data,
  input  logic [ID_W-1:0]          node_id,
  input  logic                     data_tx_flag_out,
  output logic                     tx_flag,
  output logic [ID_W+DATA_W-1:0]   data_tx_packet,
  output logic [CH_W-1:0]          tx_channel,
  output logic [NUM_CH-1:0]        fifo_full,
  output logic [NUM_CH-1:0]        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a packet transfers on a rising edge where tx_flag && data_tx_flag_out;
  // while tx_flag=1 and data_tx_flag_out=0 the packet and channel are held stable.
  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [CNT_W-1:0]  count_nxt [NUM_CH];
  logic [NUM_CH-1:0] nonempty, push_acc, pop_vec;
  logic [CH_W-1:0]   last_grant, grant;
  logic              pop, found;
  int                idx;

  assign tx_flag = (state_q == S_HOLD);

  // Round-robin search begins one past the last granted channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!found && nonempty[idx]) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (found) begin
          pop     = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (data_tx_flag_out) begin
          if (found) pop = 1'b1;
          else       state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // A full FIFO still accepts a push when it is popped on the same edge.
  always_comb begin
    pop_vec = pop ? (NUM_CH'(1) << grant) : '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty[c]  = (count[c] != '0);
      push_acc[c]  = gpp_tx_signal[c] && ((count[c] != CNT_W'(DEPTH)) || pop_vec[c]);
      count_nxt[c] = count[c] + CNT_W'(push_acc[c]) - CNT_W'(pop_vec[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst && push_acc[c]) mem[c][wr_ptr[c]] <= gpp_tx_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_EMPTY;
      last_grant     <= CH_W'(NUM_CH - 1);
      data_tx_packet <= '0;
      tx_channel     <= '0;
      fifo_full      <= '0;
      overflow       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_acc[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop_vec[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        count[c]     <= count_nxt[c];
        fifo_full[c] <= (count_nxt[c] == CNT_W'(DEPTH));
        if (gpp_tx_signal[c] && !push_acc[c]) overflow[c] <= 1'b1;
      end
      if (pop) begin
        last_grant     <= grant;
        tx_channel     <= grant;
        data_tx_packet <= {node_id, mem[grant][rd_ptr[grant]]};
      end
    end
  end

endmodule

// File: tb/tb_data_plane_tx_mc.sv
// Directed bench for data_plane_tx_mc: expected {channel, packet} values are queued
// as stimulus is driven and popped when the DUT transfers a packet.
module tb_data_plane_tx_mc;

  localparam int DATA_W = 16;
  localparam int ID_W   = 16;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 2;
  localparam int PW     = CH_W + ID_W + DATA_W;
  localparam logic [ID_W-1:0] NODE = 16'h0001;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        gpp_tx_signal;
  logic [NUM_CH*DATA_W-1:0] gpp_tx_data;
  logic [ID_W-1:0]          node_id;
  logic                     data_tx_flag_out;
  logic                     tx_flag;
  logic [ID_W+DATA_W-1:0]   data_tx_packet;
  logic [CH_W-1:0]          tx_channel;
  logic [NUM_CH-1:0]        fifo_full;
  logic [NUM_CH-1:0]        overflow;

  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int last_drain = 0;

  data_plane_tx_mc #(.DATA_W(DATA_W), .ID_W(ID_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .gpp_tx_signal(gpp_tx_signal), .gpp_tx_data(gpp_tx_data),
    .node_id(node_id), .data_tx_flag_out(data_tx_flag_out), .tx_flag(tx_flag),
    .data_tx_packet(data_tx_packet), .tx_channel(tx_channel), .fifo_full(fifo_full),
    .overflow(overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pk(input int ch, input logic [DATA_W-1:0] d);
    return {CH_W'(ch), NODE, d};
  endfunction

  // driver tasks
  task automatic push(input int ch, input logic [DATA_W-1:0] d, input bit expect_out);
    gpp_tx_signal[ch] = 1'b1;
    gpp_tx_data[ch*DATA_W +: DATA_W] = d;
    if (expect_out) exp_q.push_back(pk(ch, d));
  endtask

  // One clock: score a transfer on this edge, then check hold stability.
  task automatic cycle();
    logic xfer, hold;
    logic [PW-1:0] prev;
    xfer = tx_flag && data_tx_flag_out;
    hold = tx_flag && !data_tx_flag_out;
    prev = {tx_channel, data_tx_packet};
    if (xfer) begin
      if (exp_q.size() == 0) chk("unexpected_xfer", 64'(prev), 64'hdead);
      else chk("xfer", 64'(prev), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (hold) chk("hold_stable", 64'({tx_flag, tx_channel, data_tx_packet}), 64'({1'b1, prev}));
  endtask

  task automatic drain(input int max_cycles, input bit rand_ready);
    int n;
    n = 0;
    gpp_tx_signal = '0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      data_tx_flag_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    last_drain = n;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      gpp_tx_signal    = NUM_CH'($urandom);
      gpp_tx_data      = {$urandom, $urandom};
      data_tx_flag_out = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    rst = 1'b1;
    gpp_tx_signal    = '0;
    data_tx_flag_out = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] burst [5];
    logic [DATA_W-1:0] d;
    burst = '{16'h000A, 16'h0005, 16'h0002, 16'h0008, 16'h0001};
    gpp_tx_signal = '0;
    gpp_tx_data = '0;
    data_tx_flag_out = 1'b0;
    node_id = 16'($urandom);
    rst = 1'b0;

    // Reset with random inputs
    apply_reset(2);
    node_id = NODE;
    chk("rst_tx_flag", 64'(tx_flag), 64'd0);
    chk("rst_packet", 64'(data_tx_packet), 64'd0);
    chk("rst_channel", 64'(tx_channel), 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_tx_flag", 64'(tx_flag), 64'd0);

    // Single-channel burst on ch0, ready low
    for (int i = 0; i < 5; i++) begin
      push(0, burst[i], 1'b1);
      cycle();
      gpp_tx_signal = '0;
      if (i == 0) chk("latency_not_yet", 64'(tx_flag), 64'd0);
      if (i == 1) chk("latency_valid", 64'(tx_flag), 64'd1);
    end
    chk("burst_hold_flag", 64'(tx_flag), 64'd1);
    chk("burst_hold_pkt", 64'(data_tx_packet), 64'h0001000A);
    drain(20, 1'b0);
    chk("burst_back_to_back", 64'(last_drain), 64'd5);
    chk("burst_end_flag", 64'(tx_flag), 64'd0);

    // Round-robin across ch0, ch1, ch3 from a fresh reset
    apply_reset(1);
    for (int w = 0; w < 2; w++) begin
      push(0, DATA_W'(16'h10 + w), 1'b0);
      push(1, DATA_W'(16'h20 + w), 1'b0);
      push(3, DATA_W'(16'h30 + w), 1'b0);
      cycle();
    end
    gpp_tx_signal = '0;
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back(pk(0, DATA_W'(16'h10 + w)));
      exp_q.push_back(pk(1, DATA_W'(16'h20 + w)));
      exp_q.push_back(pk(3, DATA_W'(16'h30 + w)));
    end
    drain(20, 1'b0);
    chk("rr_back_to_back", 64'(last_drain), 64'd6);
    chk("rr_end_flag", 64'(tx_flag), 64'd0);

    // Backpressure with random ready on ch1
    for (int i = 0; i < 6; i++) begin
      push(1, DATA_W'($urandom), 1'b1);
      data_tx_flag_out = 1'($urandom_range(0, 1));
      cycle();
      gpp_tx_signal = '0;
    end
    drain(80, 1'b1);
    data_tx_flag_out = 1'b1;
    cycle();
    chk("bp_end_flag", 64'(tx_flag), 64'd0);

    // Overflow on ch2: word 0 in output reg, 1..8 queued, 9 dropped
    data_tx_flag_out = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(2, DATA_W'(i), i < 9);
      cycle();
      gpp_tx_signal = '0;
      if (i == 8) chk("full_after_8", 64'(fifo_full), 64'b0100);
      if (i == 8) chk("no_ovf_yet", 64'(overflow), 64'd0);
    end
    chk("ovf_full", 64'(fifo_full), 64'b0100);
    chk("ovf_flag", 64'(overflow), 64'b0100);
    d = 16'h0077;
    data_tx_flag_out = 1'b1;
    push(2, d, 1'b1);
    cycle();
    gpp_tx_signal = '0;
    chk("full_push_pop_full", 64'(fifo_full), 64'b0100);
    chk("full_push_pop_no_new_ovf", 64'(overflow), 64'b0100);
    drain(30, 1'b0);
    chk("ovf_sticky", 64'(overflow), 64'b0100);
    chk("ovf_full_clear", 64'(fifo_full), 64'd0);

    // Reset during a back-to-back drain on ch0
    data_tx_flag_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(0, DATA_W'(16'h40 + i), 1'b1);
      cycle();
      gpp_tx_signal = '0;
    end
    data_tx_flag_out = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    chk("midrst_tx_flag", 64'(tx_flag), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_full", 64'(fifo_full), 64'd0);
    data_tx_flag_out = 1'b0;
    cycle();
    cycle();
    chk("midrst_fifos_empty", 64'(tx_flag), 64'd0);
    push(1, 16'h0051, 1'b0);
    push(0, 16'h0050, 1'b0);
    exp_q.push_back(pk(0, 16'h0050));
    exp_q.push_back(pk(1, 16'h0051));
    cycle();
    gpp_tx_signal = '0;
    cycle();
    chk("midrst_first_ch", 64'(tx_channel), 64'd0);
    drain(20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
